signed_sat_accumulator: RTL and testbench

- Streaming accumulator that sums a packet of signed W-bit samples using saturating signed addition.
- Emits one result per packet, terminated by up_last, with a sticky "saturated" flag and the sample count.
- Consumes samples from the upstream pipeline and feeds the downstream result consumer.
- Valid/ready handshake on both sides.

---
 rtl/sat_arith_pkg.sv | 21 ++
 rtl/signed_add_sat_w.sv | 36 +++
 rtl/signed_sat_accumulator.sv | 96 +++++++++
 tb/tb_signed_sat_accumulator.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_arith_pkg.sv
// Shared types and saturation limits for the signed saturating accumulator.
package sat_arith_pkg;

   // ACC: accepting samples; HOLD: presenting a result downstream.
   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } acc_state_t;

   // Largest positive two's-complement value of width w (0111..1).
   // The caller casts the result down to its own width.
   function automatic logic [63:0] sat_max(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   // Most negative two's-complement value of width w (1000..0).
   function automatic logic [63:0] sat_min(input int w);
      return 64'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/signed_add_sat_w.sv
// Combinational W-bit signed adder that clamps to the representable range
// and reports whether clamping happened.
module signed_add_sat_w
   import sat_arith_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         sat
);

   localparam logic [W-1:0] MAX_V = W'(sat_max(W));
   localparam logic [W-1:0] MIN_V = W'(sat_min(W));

   logic [W-1:0] p;
   logic         pos_ovf;
   logic         neg_ovf;

   // Overflow is only possible when both operands share a sign and the
   // wrapped sum's sign differs from it.
   always_comb begin
      p       = a + b;
      pos_ovf = ~a[W-1] & ~b[W-1] &  p[W-1];
      neg_ovf =  a[W-1] &  b[W-1] & ~p[W-1];
      sat     = pos_ovf | neg_ovf;
      sum     = p;
      if (pos_ovf) begin
         sum = MAX_V;
      end else if (neg_ovf) begin
         sum = MIN_V;
      end
   end

endmodule

// File: rtl/signed_sat_accumulator.sv
// Packet accumulator: sums signed samples with per-step saturation and
// emits one registered result (sum, sticky saturation flag, sample count)
// per packet.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   ACC   | up_ready=1; accumulate samples until up_last handshake
//   HOLD  | down_valid=1; result held stable until down_ready
module signed_sat_accumulator
   import sat_arith_pkg::*;
#(
   parameter int W     = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic [W-1:0]     up_data,
   input  logic             up_last,
   output logic             down_valid,
   input  logic             down_ready,
   output logic [W-1:0]     down_sum,
   output logic             down_sat,
   output logic [CNT_W-1:0] down_count
);

   acc_state_t       state;
   acc_state_t       state_nxt;
   logic [W-1:0]     acc;
   logic             sat_flag;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [W-1:0]     add_sum;
   logic             add_sat;
   logic             take;

   // Handshake signals decode state only, so there is no input-to-output path.
   assign up_ready   = (state == ACC);
   assign down_valid = (state == HOLD);
   assign take       = up_valid & up_ready;
   assign cnt_inc    = (&cnt) ? cnt : cnt + CNT_W'(1);

   signed_add_sat_w #(.W(W)) u_add (
      .a   (acc),
      .b   (up_data),
      .sum (add_sum),
      .sat (add_sat)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ACC;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         ACC:     if (take && up_last) state_nxt = HOLD;
         HOLD:    if (down_ready)      state_nxt = ACC;
         default: state_nxt = ACC;
      endcase
   end

   // Accumulator, counter and result registers; the last sample's step
   // goes straight into the result so the packet state can be cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc        <= '0;
         sat_flag   <= 1'b0;
         cnt        <= '0;
         down_sum   <= '0;
         down_sat   <= 1'b0;
         down_count <= '0;
      end else if (take) begin
         if (up_last) begin
            down_sum   <= add_sum;
            down_sat   <= sat_flag | add_sat;
            down_count <= cnt_inc;
            acc        <= '0;
            sat_flag   <= 1'b0;
            cnt        <= '0;
         end else begin
            acc      <= add_sum;
            sat_flag <= sat_flag | add_sat;
            cnt      <= cnt_inc;
         end
      end
   end

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Directed bench for signed_sat_accumulator: W=4/CNT_W=8 main instance and
// a W=4/CNT_W=2 instance for count saturation.
module tb_signed_sat_accumulator;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       u_valid = 1'b0, u_last = 1'b0, d_ready = 1'b0;
   logic [3:0] u_data = '0;
   logic       u_ready, d_valid, d_sat;
   logic [3:0] d_sum;
   logic [7:0] d_cnt;

   logic       v_valid = 1'b0, v_last = 1'b0, e_ready = 1'b0;
   logic [3:0] v_data = '0;
   logic       v_ready, e_valid, e_sat;
   logic [3:0] e_sum;
   logic [1:0] e_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   signed_sat_accumulator #(.W(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .up_valid(u_valid), .up_ready(u_ready), .up_data(u_data), .up_last(u_last),
      .down_valid(d_valid), .down_ready(d_ready),
      .down_sum(d_sum), .down_sat(d_sat), .down_count(d_cnt)
   );

   signed_sat_accumulator #(.W(4), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst),
      .up_valid(v_valid), .up_ready(v_ready), .up_data(v_data), .up_last(v_last),
      .down_valid(e_valid), .down_ready(e_ready),
      .down_sum(e_sum), .down_sat(e_sat), .down_count(e_cnt)
   );

   // Present one sample and hold it until the handshake edge has passed.
   task automatic send(input int which, input logic [3:0] d, input logic last);
      int n;
      n = 0;
      @(negedge clk);
      if (which == 0) begin u_valid = 1'b1; u_data = d; u_last = last; end
      else            begin v_valid = 1'b1; v_data = d; v_last = last; end
      while (((which == 0) ? u_ready : v_ready) !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         n_cmp++; n_err++;
         $display("FAIL send_timeout: up_ready never 1 on dut%0d, required 1", which);
      end
      @(posedge clk);
      #1;
      if (which == 0) begin u_valid = 1'b0; u_last = 1'b0; end
      else            begin v_valid = 1'b0; v_last = 1'b0; end
   endtask

   // Pulse down_ready for one clock edge.
   task automatic accept(input int which);
      @(negedge clk);
      if (which == 0) d_ready = 1'b1; else e_ready = 1'b1;
      @(posedge clk);
      #1;
      if (which == 0) d_ready = 1'b0; else e_ready = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      n_cmp++;
      if ({d_valid, d_sum, d_sat, d_cnt} !== 14'h0) begin
         n_err++;
         $display("FAIL reset_during: got valid/sum/sat/cnt %h required 0", {d_valid, d_sum, d_sat, d_cnt});
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({u_ready, d_valid, d_sum, d_sat, d_cnt} !== {1'b1, 14'h0}) begin
         n_err++;
         $display("FAIL reset_values: got %h required %h", {u_ready, d_valid, d_sum, d_sat, d_cnt}, {1'b1, 14'h0});
      end
   endtask

   task automatic test_pos_sat;
      send(0, 4'd3, 1'b0);
      send(0, 4'd4, 1'b1);
      n_cmp++;
      if ({d_valid, d_sum, d_sat, d_cnt} !== {1'b1, 4'h7, 1'b0, 8'd2}) begin
         n_err++;
         $display("FAIL pos_nosat: got v/sum/sat/cnt %b/%h/%b/%0d required 1/7/0/2", d_valid, d_sum, d_sat, d_cnt);
      end
      accept(0);
      n_cmp++;
      if ({d_valid, u_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL accept_release: got valid/ready %b%b required 01", d_valid, u_ready);
      end
      send(0, 4'd3, 1'b0);
      send(0, 4'd5, 1'b1);
      n_cmp++;
      if ({d_valid, d_sum, d_sat, d_cnt} !== {1'b1, 4'h7, 1'b1, 8'd2}) begin
         n_err++;
         $display("FAIL pos_sat: got v/sum/sat/cnt %b/%h/%b/%0d required 1/7/1/2", d_valid, d_sum, d_sat, d_cnt);
      end
      accept(0);
   endtask

   task automatic test_neg_sat;
      send(0, 4'hB, 1'b0);   // -5
      send(0, 4'hA, 1'b1);   // -6
      n_cmp++;
      if ({d_valid, d_sum, d_sat, d_cnt} !== {1'b1, 4'h8, 1'b1, 8'd2}) begin
         n_err++;
         $display("FAIL neg_sat: got v/sum/sat/cnt %b/%h/%b/%0d required 1/8/1/2", d_valid, d_sum, d_sat, d_cnt);
      end
      accept(0);
      send(0, 4'hD, 1'b0);   // -3
      send(0, 4'hB, 1'b1);   // -5
      n_cmp++;
      if ({d_valid, d_sum, d_sat, d_cnt} !== {1'b1, 4'h8, 1'b0, 8'd2}) begin
         n_err++;
         $display("FAIL neg_exact: got v/sum/sat/cnt %b/%h/%b/%0d required 1/8/0/2", d_valid, d_sum, d_sat, d_cnt);
      end
      accept(0);
   endtask

   task automatic test_per_step;
      send(0, 4'd7, 1'b0);
      send(0, 4'd1, 1'b0);
      send(0, 4'hF, 1'b1);   // -1
      n_cmp++;
      if ({d_valid, d_sum, d_sat, d_cnt} !== {1'b1, 4'h6, 1'b1, 8'd3}) begin
         n_err++;
         $display("FAIL per_step: got v/sum/sat/cnt %b/%h/%b/%0d required 1/6/1/3", d_valid, d_sum, d_sat, d_cnt);
      end
      accept(0);
   endtask

   task automatic test_back_to_back;
      send(0, 4'd1, 1'b0);
      send(0, 4'd2, 1'b1);
      @(negedge clk);
      u_valid = 1'b1; u_data = 4'd5; u_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({u_ready, d_valid, d_sum, d_sat, d_cnt} !== {1'b0, 1'b1, 4'h3, 1'b0, 8'd2}) begin
            n_err++;
            $display("FAIL backpressure_%0d: got rdy/v/sum/sat/cnt %b/%b/%h/%b/%0d required 0/1/3/0/2",
                     i, u_ready, d_valid, d_sum, d_sat, d_cnt);
         end
         @(negedge clk);
      end
      d_ready = 1'b1;
      @(posedge clk);
      #1;
      d_ready = 1'b0;
      n_cmp++;
      if ({d_valid, u_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL bubble: got valid/ready %b%b required 01", d_valid, u_ready);
      end
      @(posedge clk);
      #1;
      u_valid = 1'b0; u_last = 1'b0;
      n_cmp++;
      if ({d_valid, d_sum, d_sat, d_cnt} !== {1'b1, 4'h5, 1'b0, 8'd1}) begin
         n_err++;
         $display("FAIL second_pkt: got v/sum/sat/cnt %b/%h/%b/%0d required 1/5/0/1", d_valid, d_sum, d_sat, d_cnt);
      end
      accept(0);
   endtask

   task automatic test_async_reset;
      send(0, 4'd4, 1'b1);
      #3;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({u_ready, d_valid, d_sum, d_sat, d_cnt} !== {1'b1, 14'h0}) begin
         n_err++;
         $display("FAIL reset_in_hold: got rdy/v/sum/sat/cnt %b/%b/%h/%b/%0d required 1/0/0/0/0",
                  u_ready, d_valid, d_sum, d_sat, d_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      send(0, 4'd3, 1'b0);
      send(0, 4'd2, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({u_ready, d_valid, d_sum, d_cnt} !== {1'b1, 1'b0, 4'h0, 8'd0}) begin
         n_err++;
         $display("FAIL reset_mid_pkt: got rdy/v/sum/cnt %b/%b/%h/%0d required 1/0/0/0", u_ready, d_valid, d_sum, d_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      send(0, 4'd2, 1'b1);
      n_cmp++;
      if ({d_valid, d_sum, d_sat, d_cnt} !== {1'b1, 4'h2, 1'b0, 8'd1}) begin
         n_err++;
         $display("FAIL after_reset: got v/sum/sat/cnt %b/%h/%b/%0d required 1/2/0/1", d_valid, d_sum, d_sat, d_cnt);
      end
      accept(0);
   endtask

   task automatic test_cnt_sat;
      for (int i = 0; i < 4; i++) send(1, 4'd0, 1'b0);
      send(1, 4'd0, 1'b1);
      n_cmp++;
      if ({e_valid, e_sum, e_sat, e_cnt} !== {1'b1, 4'h0, 1'b0, 2'd3}) begin
         n_err++;
         $display("FAIL cnt_sat: got v/sum/sat/cnt %b/%h/%b/%0d required 1/0/0/3", e_valid, e_sum, e_sat, e_cnt);
      end
      accept(1);
      n_cmp++;
      if ({e_valid, v_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL cnt_accept: got valid/ready %b%b required 01", e_valid, v_ready);
      end
   endtask

   initial begin
      test_reset();
      test_pos_sat();
      test_neg_sat();
      test_per_step();
      test_back_to_back();
      test_async_reset();
      test_cnt_sat();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at 100000, required finished");
      $fatal(1);
   end

endmodule
